// File: rtl/toff_pkg.sv
// Shared definitions for the reversible-gate sequencer: op encodings, FSM states
// and the layout of a gate-program entry {op, c1, c2, tgt}.
package toff_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_NOT  = 2'b01;
    localparam logic [1:0] OP_CNOT = 2'b10;
    localparam logic [1:0] OP_TOFF = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Entry fields sit in IDXW-wide slots, lsb = slot * IDXW; op occupies the top two bits.
    localparam int TGT_SLOT = 0;
    localparam int C2_SLOT  = 1;
    localparam int C1_SLOT  = 2;
    localparam int OP_SLOT  = 3;

    function automatic int gate_width(input int idxw);
        return 2 + 3 * idxw;
    endfunction

endpackage

// File: rtl/toff_apply.sv
// Combinational reversible-gate cell: applies one program entry to the line vector.
// Entries whose indices collide or fall outside the register behave as NOP.
module toff_apply
    import toff_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int IDXW = $clog2(WIDTH),
    localparam int GW   = gate_width(IDXW)
) (
    input  logic [WIDTH-1:0] lines,
    input  logic [GW-1:0]    entry,
    output logic [WIDTH-1:0] lines_next
);

    logic [1:0]      op;
    logic [IDXW-1:0] c1;
    logic [IDXW-1:0] c2;
    logic [IDXW-1:0] tgt;
    logic            c1_val;
    logic            c2_val;
    logic            c1_ok;
    logic            c2_ok;
    logic            tgt_ok;
    logic            flip;

    assign op  = entry[OP_SLOT*IDXW +: 2];
    assign c1  = entry[C1_SLOT*IDXW +: IDXW];
    assign c2  = entry[C2_SLOT*IDXW +: IDXW];
    assign tgt = entry[TGT_SLOT*IDXW +: IDXW];

    always_comb begin
        c1_val     = 1'b0;
        c2_val     = 1'b0;
        flip       = 1'b0;
        lines_next = lines;
        tgt_ok     = (int'(tgt) < WIDTH);
        c1_ok      = (int'(c1) < WIDTH) && (c1 != tgt);
        c2_ok      = (int'(c2) < WIDTH) && (c2 != tgt);

        // Loop-based selects keep out-of-range indices from ever addressing the vector.
        for (int i = 0; i < WIDTH; i++) begin
            if (i == int'(c1)) c1_val = lines[i];
            if (i == int'(c2)) c2_val = lines[i];
        end

        case (op)
            OP_NOT:  flip = tgt_ok;
            OP_CNOT: flip = tgt_ok && c1_ok && c1_val;
            OP_TOFF: flip = tgt_ok && c1_ok && c2_ok && c1_val && c2_val;
            default: flip = 1'b0;
        endcase

        for (int i = 0; i < WIDTH; i++) begin
            if (i == int'(tgt)) lines_next[i] = lines[i] ^ flip;
        end
    end

endmodule

// File: rtl/toff_seq_ctrl.sv
// Gate-program sequencer: runs a stored NOT/CNOT/Toffoli cascade forward or reversed, one gate per clock.
// Optional TOFF_REV_CHECK_EN: forward runs are replayed reversed and compared with din, flagged on err.
module toff_seq_ctrl
    import toff_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int IDXW = $clog2(WIDTH),
    localparam int PCW  = $clog2(DEPTH),
    localparam int LENW = $clog2(DEPTH + 1),
    localparam int GW   = gate_width(IDXW)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [PCW-1:0]   cfg_addr,
    input  logic [GW-1:0]    cfg_data,
    input  logic             len_we,
    input  logic [LENW-1:0]  len,
    input  logic             start,
    input  logic             dir,
    input  logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             done,
`ifdef TOFF_REV_CHECK_EN
    output logic             err,
`endif
    output logic [WIDTH-1:0] dout
);

    logic [GW-1:0]    prog_mem [DEPTH];
    logic [GW-1:0]    prog_run [DEPTH];
    state_t           state;
    logic [PCW-1:0]   pc;
    logic [LENW-1:0]  cnt;
    logic [LENW-1:0]  len_reg;
    logic [LENW-1:0]  len_sat;
    logic             run_dir;
    logic             accept;
    logic [WIDTH-1:0] lines;
    logic [WIDTH-1:0] lines_next;
    logic [GW-1:0]    entry;

`ifdef TOFF_REV_CHECK_EN
    logic             check;
    logic             rev_phase;
    logic [LENW-1:0]  len_run;
    logic [WIDTH-1:0] din_save;
    logic [WIDTH-1:0] fwd_save;
`endif

    // The cycle carrying the done pulse still belongs to the finishing run.
    assign accept  = (state == ST_IDLE) && !done;
    assign len_sat = (int'(len) > DEPTH) ? LENW'(DEPTH) : len;
    assign entry   = prog_run[pc];
    assign dout    = lines;

    toff_apply #(.WIDTH(WIDTH)) u_apply (
        .lines      (lines),
        .entry      (entry),
        .lines_next (lines_next)
    );

    always_ff @(posedge clk) begin
        if (accept && cfg_we) prog_mem[cfg_addr] <= cfg_data;
    end

    // Snapshot at start so a same-cycle config write only affects later runs.
    always_ff @(posedge clk) begin
        if (accept && start) prog_run <= prog_mem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            lines     <= '0;
            pc        <= '0;
            cnt       <= '0;
            len_reg   <= '0;
            run_dir   <= 1'b0;
`ifdef TOFF_REV_CHECK_EN
            err       <= 1'b0;
            check     <= 1'b0;
            rev_phase <= 1'b0;
            len_run   <= '0;
            din_save  <= '0;
            fwd_save  <= '0;
`endif
        end else begin
            done <= 1'b0;
            if (accept && len_we) len_reg <= len_sat;

            case (state)
                ST_IDLE: begin
                    if (accept && start) begin
                        lines   <= din;
                        run_dir <= dir;
                        cnt     <= len_reg;
                        pc      <= dir ? PCW'(len_reg - LENW'(1)) : '0;
`ifdef TOFF_REV_CHECK_EN
                        err       <= 1'b0;
                        check     <= !dir;
                        rev_phase <= 1'b0;
                        len_run   <= len_reg;
                        din_save  <= din;
`endif
                        if (len_reg == '0) begin
                            state <= ST_DONE;
                        end else begin
                            state <= ST_RUN;
                            busy  <= 1'b1;
                        end
                    end
                end

                ST_RUN: begin
                    lines <= lines_next;
                    cnt   <= cnt - LENW'(1);
                    if (cnt == LENW'(1)) begin
`ifdef TOFF_REV_CHECK_EN
                        // Reverse pass starts on the entry just executed, so pc holds.
                        if (check && !rev_phase) begin
                            fwd_save  <= lines_next;
                            rev_phase <= 1'b1;
                            run_dir   <= 1'b1;
                            cnt       <= len_run;
                        end else begin
                            state <= ST_DONE;
                            busy  <= 1'b0;
                        end
`else
                        state <= ST_DONE;
                        busy  <= 1'b0;
`endif
                    end else begin
                        pc <= run_dir ? pc - PCW'(1) : pc + PCW'(1);
                    end
                end

                ST_DONE: begin
                    done  <= 1'b1;
                    state <= ST_IDLE;
`ifdef TOFF_REV_CHECK_EN
                    if (rev_phase) begin
                        lines <= fwd_save;
                        err   <= (lines != din_save);
                    end
`endif
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/toff_seq_ctrl.md
Name: toff_seq_ctrl

Overview:
- Sequencer for a cascade of reversible gates (NOT / CNOT / Toffoli) applied to a WIDTH-bit line register.
- Holds a small gate program loaded through a config port.
- On a start handshake, executes one gate per clock, forward or reversed (uncompute), and returns the result with a one-cycle done pulse.
- Sits between the host test/config logic and the combinational Toffoli cell; the block sequences and shares that cell across all program steps.

Parameters:
- WIDTH, 4, number of reversible lines (min 3).
- DEPTH, 8, gate program entries (power of 2).
- Derived localparams: IDXW = clog2(WIDTH), PCW = clog2(DEPTH), LENW = clog2(DEPTH+1), GW = 2+3*IDXW.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  write gate entry.
- cfg_addr  in  PCW  entry index.
- cfg_data  in  GW  entry {op[1:0], c1, c2, tgt}; op 00=NOP, 01=NOT, 10=CNOT, 11=TOFF.
- len_we  in  1  write program length.
- len  in  LENW  number of gates to run, 0..DEPTH (values >DEPTH saturate to DEPTH).
- start  in  1  start request, sampled in IDLE only.
- dir  in  1  0 = entries 0..len-1; 1 = entries len-1..0; sampled with start.
- din  in  WIDTH  initial line values, sampled with start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse, result valid.
- dout  out  WIDTH  line register.

Behaviour:
- Clock is clk; reset is rst_n, asynchronous, active-low.
- Reset (async, any time incl. mid-run): state=IDLE, busy=0, done=0, dout=0, program length=0. Gate memory is not reset; entries read as undefined until written.
- Gate semantics, applied at a rising edge:
  - NOT: L[tgt] ^= 1.
  - CNOT: L[tgt] ^= L[c1].
  - TOFF: L[tgt] ^= L[c1] & L[c2].
- Illegal entries execute as NOP: CNOT/TOFF with tgt==c1, TOFF with tgt==c2, or any index >= WIDTH.
- FSM IDLE -> RUN -> DONE -> IDLE.
  - IDLE: start=1 loads L=din, pc = dir ? len_reg-1 : 0, cnt=len_reg. Next state is RUN, or DONE if len_reg==0.
  - RUN: one gate per cycle at pc; pc steps +1 (dir=0) or -1 (dir=1); cnt decrements. After the gate with cnt==1, next state is DONE.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency: start sampled at edge T0; done high in the cycle after edge T0+len+1 (len=0 gives done after edge T0+1).
- dout reflects L continuously. It changes during RUN and is stable in DONE/IDLE until the next start.
- cfg_we, len_we and start are ignored while busy or in DONE.
- Simultaneous cfg_we/len_we and start in IDLE: the write takes effect; the run uses the old program/length.
- pc never wraps: cnt bounds execution.

Optional Feature:
- Macro TOFF_REV_CHECK_EN.
- Defined:
  - Adds output err (1 bit, reset 0).
  - For a dir=0 run, after the forward pass the block saves the result and replays the same program reversed.
  - It compares the final L with the saved din; err = mismatch, registered with done. dout = forward result.
  - done at 2*len+1 cycles after start.
  - A dir=1 run performs no check; err=0.
- Not defined: no err port, no replay, timing as above.

Decomposition:
- Package toff_pkg: op encoding constants (OP_NOP, OP_NOT, OP_CNOT, OP_TOFF), FSM state enum, gate-entry field offsets.
- One sub-module: toff_apply, purely combinational. It takes (L, entry) and returns L', including the illegal-entry NOP rule. It is instantiated once and shared by every RUN cycle.

Test Plan:
- Single gate: len=1, entry0 TOFF c1=0, c2=1, tgt=2; din=0011 -> done 2 cycles after start, dout=0111. din=0001 -> dout=0001.
- Three gates: NOT t0; CNOT c0->t1; TOFF c0,c1->t3; din=0000, dir=0 -> dout=1011 at 4 cycles. Then dir=1, din=1011 -> dout=0000.
- len=0, din=1010 -> done 1 cycle after start, dout=1010, busy never high.
- Illegal entry CNOT c1=2, tgt=2, din=0100 -> dout=0100. cfg_we and a second start during busy -> program and result unchanged.
- rst_n low mid-RUN (cycle 2 of 3) -> immediately busy=0, done=0, dout=0. A post-reset start with len_we-reloaded program runs cleanly.
- With TOFF_REV_CHECK_EN defined: the three-gate program, din=0000 -> done at 7 cycles, dout=1011, err=0.
